popcount_sched: RTL and testbench
=================================

POPCOUNT_SCHED -- requirements
Module: popcount_sched

Interface
REQ-001 SHALL provide parameter N_REQ, default 4, number of requesters sharing the ones-count datapath (power of 2, >=2).
REQ-002 SHALL provide parameter WIDTH, default 8, operand width in bits.
REQ-003 SHALL derive IW = log2(N_REQ) and CW = ceil(log2(WIDTH+1)).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  N_REQ  per-requester request; held high until the matching ack.
REQ-008 operand  input  N_REQ*WIDTH  requester i operand in bits [i*WIDTH +: WIDTH]; valid while req[i] is high.
REQ-009 ack  output  N_REQ  one-hot, one-cycle grant/capture pulse.
REQ-010 res_valid  output  1  result available.
REQ-011 res_id  output  IW  index of the requester owning the result.
REQ-012 res_count  output  CW  number of 1 bits in the captured operand.
REQ-013 res_ready  input  1  consumer accepts the result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, TEST, INC, SHIFT and OUTPUT, with an internal WIDTH-bit shift register A, a CW-bit counter CNT, an IW-bit register ID and an IW-bit round-robin pointer PTR.
REQ-016 In IDLE with any req bit high, SHALL grant the first requester at or above PTR, wrapping modulo N_REQ; ack[winner] SHALL be high combinationally in that cycle only.
REQ-017 On the grant edge, SHALL load A from operand[winner], clear CNT, load ID with the winner index and move to TEST.
REQ-018 In IDLE with req all zero, SHALL stay in IDLE with ack at 0.
REQ-019 In TEST, SHALL move to OUTPUT when A is 0, to INC when A[0] is 1, and to SHIFT otherwise.
REQ-020 In INC, SHALL increment CNT by 1 (no saturation needed; the maximum is WIDTH) and move to SHIFT.
REQ-021 In SHIFT, SHALL logically shift A right by 1 with zero fill and move to TEST.
REQ-022 In OUTPUT, SHALL hold res_valid at 1 with res_count = CNT and res_id = ID, stable until accepted.
REQ-023 In OUTPUT, on res_ready = 1, SHALL set PTR to (ID+1) mod N_REQ and move to IDLE; no grant SHALL occur in an OUTPUT cycle.
REQ-024 Latency: with L = index of the operand MSB set + 1 (L = 0 for a zero operand) and K = popcount, res_valid SHALL first assert 2L+K+2 cycles after the ack cycle.
REQ-025 A requester keeping req high after its ack SHALL be treated as a new request at the next IDLE.
REQ-026 Changes to req or operand outside IDLE SHALL be ignored.
REQ-027 ack SHALL be 0 and res_valid SHALL be 0 in every state other than IDLE and OUTPUT respectively.

Reset
REQ-028 While rst is high, state SHALL be IDLE, and PTR, ID, CNT, A, ack, res_valid, res_id, res_count and busy SHALL all be 0.
REQ-029 rst SHALL take priority over every other event, including a grant or res_ready in the same cycle.
REQ-030 rst mid-operation SHALL discard the in-flight operand, produce no result, and issue no ack in the reset cycle.

Verification
REQ-031 req=0001, operand0=0x00, res_ready=1 -> ack=0001 at t; res_valid at t+2 with res_count=0, res_id=0; back in IDLE at t+3.
REQ-032 req=0100, operand2=0xB5 -> res_valid 23 cycles after ack with res_count=5, res_id=2; operand 0xFF -> res_count=8 after 26 cycles.
REQ-033 req=1111 held continuously, res_ready=1 -> grants in the order 0,1,2,3,0; ack is one-hot; no requester is granted twice before the others.
REQ-034 res_ready=0 for 10 cycles in OUTPUT -> res_valid, res_count and res_id stay stable and busy=1; release -> IDLE the next cycle.
REQ-035 rst asserted in SHIFT with req=0010 still high -> the next cycle is IDLE with all outputs 0; the following cycle gives ack=0010 (PTR=0, winner 1).
REQ-036 req rises for requester 3 while requester 0 is in TEST -> no ack until OUTPUT is accepted; then requester 3 is granted from IDLE.

Source files
------------

// File: rtl/popcount_sched.sv
// Round-robin scheduler sharing one bit-serial ones counter among N_REQ requesters.
// Each granted operand is tested and shifted one bit at a time until it is zero.
module popcount_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] operand,
  output logic [N_REQ-1:0]       ack,
  output logic                   res_valid,
  output logic [IW-1:0]          res_id,
  output logic [CW-1:0]          res_count,
  input  logic                   res_ready,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TEST   = 3'd1,
    INC    = 3'd2,
    SHIFT  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  localparam logic [N_REQ-1:0] ACK_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      id_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      cand;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic               grant;

  // Scan from PTR upward; IW-bit addition wraps modulo N_REQ for free.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr_q + IW'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant   = 1'b1;
          state_d = TEST;
        end
      end
      TEST: begin
        if (a_q == '0)  state_d = OUTPUT;
        else if (a_q[0]) state_d = INC;
        else             state_d = SHIFT;
      end
      INC:    state_d = SHIFT;
      SHIFT:  state_d = TEST;
      OUTPUT: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant) begin
            a_q   <= operand[int'(win_idx)*WIDTH +: WIDTH];
            cnt_q <= '0;
            id_q  <= win_idx;
          end
        end
        INC:    cnt_q <= cnt_q + CW'(1);
        SHIFT:  a_q   <= a_q >> 1;
        OUTPUT: if (res_ready) ptr_q <= id_q + IW'(1);
        default: ;
      endcase
    end
  end

  // Outputs are forced low during reset so the reset cycle itself is quiet.
  assign ack       = (grant && !rst) ? (ACK_ONE << win_idx) : '0;
  assign res_valid = !rst && (state_q == OUTPUT);
  assign res_id    = res_valid ? id_q : '0;
  assign res_count = res_valid ? cnt_q : '0;
  assign busy      = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_popcount_sched.sv
// Directed bench for popcount_sched: vector table for grant order, latency and
// counts, plus hand sequences for back-pressure, mid-operation reset and late requests.
module tb_popcount_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] operand;
  logic [3:0]  ack;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [3:0]  res_count;
  logic        res_ready;
  logic        busy;

  int total  = 0;
  int passed = 0;

  popcount_sched #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .operand(operand), .ack(ack),
    .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] ops;
    int          exp_id;
    int          exp_cnt;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 100);
  endtask

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return one << idx;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int spurious;
    bit found;

    vecs[0] = '{4'b0001, 32'h0000_0000, 0, 0, 2};
    vecs[1] = '{4'b0100, 32'h00B5_0000, 2, 5, 23};
    vecs[2] = '{4'b0100, 32'h00FF_0000, 2, 8, 26};
    vecs[3] = '{4'b0011, 32'h0000_8001, 0, 1, 5};
    vecs[4] = '{4'b0011, 32'h0000_8001, 1, 1, 19};
    vecs[5] = '{4'b1001, 32'h0F00_00FF, 3, 4, 14};
    vecs[6] = '{4'b1010, 32'hFF00_AA00, 1, 4, 22};
    vecs[7] = '{4'b0001, 32'h0000_0055, 0, 4, 20};

    rst       = 1'b1;
    req       = 4'b1111;
    operand   = '0;
    res_ready = 1'b1;
    step();
    @(negedge clk);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_outputs", {res_valid, busy, res_id, res_count}, 32'h0);
    step();
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    check("idle_no_req_ack", 32'(ack), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    step();

    for (int i = 0; i < 8; i++) begin
      req     = vecs[i].req;
      operand = vecs[i].ops;
      @(negedge clk);
      check($sformatf("v%0d_ack", i), 32'(ack), 32'(onehot(vecs[i].exp_id)));
      step();
      req = '0;
      wait_valid(n);
      check($sformatf("v%0d_latency", i), n, vecs[i].lat);
      check($sformatf("v%0d_count", i), 32'(res_count), vecs[i].exp_cnt);
      check($sformatf("v%0d_id", i), 32'(res_id), vecs[i].exp_id);
      check($sformatf("v%0d_busy_out", i), 32'(busy), 32'h1);
      step();
      @(negedge clk);
      check($sformatf("v%0d_idle_after", i), {res_valid, busy}, 32'h0);
      step();
    end

    // Round robin with all requesters held high.
    do_reset();
    req     = 4'b1111;
    operand = '0;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        if (ack != 0) found = 1'b1;
      end
      check($sformatf("rr_grant%0d", g), 32'(ack), 32'(onehot(g % 4)));
      check($sformatf("rr_onehot%0d", g), 32'($onehot(ack)), 32'h1);
      step();
    end
    req = '0;
    wait_valid(n);
    step();

    // Back-pressure: result must hold while res_ready is low.
    do_reset();
    req       = 4'b0001;
    operand   = 32'h0000_0003;
    res_ready = 1'b0;
    @(negedge clk);
    check("bp_ack", 32'(ack), 32'h1);
    step();
    req = '0;
    wait_valid(n);
    check("bp_latency", n, 8);
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), {res_valid, busy, res_count, res_id}, {2'b11, 4'd2, 2'd0});
    end
    step();
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_cycle", 32'(res_valid), 32'h1);
    step();
    @(negedge clk);
    check("bp_idle", {res_valid, busy}, 32'h0);
    step();

    // Reset during SHIFT with the requester still asserting.
    do_reset();
    req     = 4'b0010;
    operand = 32'h0000_0200;
    @(negedge clk);
    check("mr_ack", 32'(ack), 32'h2);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("mr_rst_cycle", {ack, res_valid, busy, res_id, res_count}, 32'h0);
    step();
    @(negedge clk);
    check("mr_idle_cycle", {ack, res_valid, busy, res_id, res_count}, 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mr_regrant", 32'(ack), 32'h2);
    step();
    req = '0;
    wait_valid(n);
    check("mr_latency", n, 7);
    check("mr_result", {res_count, res_id}, {4'd1, 2'd1});
    step();
    step();

    // Late request arriving while another operand is in flight.
    do_reset();
    req     = 4'b0001;
    operand = 32'h0700_0001;
    @(negedge clk);
    check("late_ack0", 32'(ack), 32'h1);
    step();
    req      = 4'b1000;
    n        = 0;
    spurious = 0;
    do begin
      @(negedge clk);
      n++;
      if (ack != 0) spurious++;
    end while (!res_valid && n < 100);
    check("late_no_ack_busy", spurious, 0);
    check("late_latency0", n, 5);
    check("late_id0", 32'(res_id), 32'h0);
    step();
    @(negedge clk);
    check("late_ack3", 32'(ack), 32'h8);
    step();
    req = '0;
    wait_valid(n);
    check("late_latency3", n, 11);
    check("late_result3", {res_count, res_id}, {4'd3, 2'd3});
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
